block_tracker: RTL and testbench
================================

# block_tracker

Parametrised in-flight block tracker for the G-tile, managing up to `NUM_SLOTS` speculative blocks as an age-ordered ring. It tracks per-block termination from the header: store mask by LSID, register-write count and exactly one branch. It commits complete blocks strictly oldest-first, flushes younger blocks on an EXIT_ID mis-exit, and re-arms S-morph loop blocks in place (revitalization) without reallocation.

## Interface
Parameters:
- `NUM_SLOTS`, 8, in-flight block capacity; power of two, ≥2; `SLOT_W = $clog2(NUM_SLOTS)`
- `MAX_STORES`, 32, LSIDs per block; `LSID_W = $clog2(MAX_STORES)`
- `WR_W`, 6, width of register-write count
- `EXIT_W`, 3, EXIT_ID width
- `ADDR_W`, 32, block address width

Ports (one clock; reset is synchronous and active-high):
- `clk  in  1  clock`
- `rst  in  1  synchronous active-high reset`
- `morph_s  in  1  S-morph mode enable (quasi-static)`
- `alloc_valid / alloc_ready  in / out  1  allocation handshake`
- `alloc_addr  in  ADDR_W  block address`; `alloc_store_mask  in  MAX_STORES`; `alloc_num_writes  in  WR_W`; `alloc_pred_exit  in  EXIT_W  predicted exit`; `alloc_iters  in  8  revitalize count`
- `alloc_id  out  SLOT_W  slot granted (= tail)`
- `st_valid  in  1`; `st_slot  in  SLOT_W`; `st_lsid  in  LSID_W  store arrival`
- `wr_valid  in  1`; `wr_slot  in  SLOT_W  register-write arrival`
- `br_valid  in  1`; `br_slot  in  SLOT_W`; `br_exit  in  EXIT_W`; `br_target  in  ADDR_W  branch resolution`
- `commit_valid / commit_ready  out / in  1  commit handshake for head slot`
- `commit_slot  out  SLOT_W`; `commit_addr  out  ADDR_W`; `commit_exit  out  EXIT_W`
- `flush_valid  out  1`; `flush_mask  out  NUM_SLOTS`; `flush_addr  out  ADDR_W  redirect target`
- `revitalize  out  1`; `revit_slot  out  SLOT_W`
- `inflight  out  NUM_SLOTS  occupied-slot bitmap`

## Operation
- Ring state: `head`, `tail` and `count` (0..NUM_SLOTS). Each slot holds state FREE/EXEC/DONE, address, store mask, received-LSID mask, write count, branch-seen flag, actual/predicted exit, target and remaining iterations.
- `alloc_ready = !rst && count < NUM_SLOTS`. On handshake, the tail slot is loaded and set to EXEC, `tail++` (wraps), `count++`.
- Store event: sets `rcv[st_lsid]` only if the slot is EXEC and `store_mask[st_lsid]`=1. Otherwise ignored; duplicates are idempotent.
- Write event: increments the count only if the slot is EXEC and the count is below `num_writes`. Excess writes are ignored.
- Branch event: accepted only if the slot is EXEC and no branch has been seen. Records exit and target.
  - If `br_exit != pred_exit`, the branch is a mis-exit. All slots younger than `br_slot` go FREE, including any slot allocated in the same cycle. `tail = br_slot+1`, and `count` is adjusted accordingly.
- EXEC→DONE when `rcv == store_mask`, write count equals `num_writes`, and a branch has been seen. A block with an empty mask and 0 writes needs only its branch.
- `commit_valid` = head slot DONE. On `commit_valid && commit_ready`:
  - Revitalize case (when compiled in): if `morph_s` is set and iters>0, decrement iters, clear the rcv mask, write count and branch flag, keep the header fields (constants preserved), return the slot to EXEC and leave `head` unchanged.
  - Otherwise, free the slot, `head++`, `count--`.
- Same-cycle commit and alloc: `count` is unchanged and both take effect.
- A commit and a flush in the same cycle never target the same slot, because a flush frees only slots younger than the branch.

## Timing
- Reset values: `alloc_ready`, `commit_valid`, `flush_valid` and `revitalize` are 0. `alloc_id`, `commit_*`, `flush_mask`, `flush_addr`, `revit_slot` and `inflight` are 0. Head, tail and count are 0, and all slots are FREE.
- Reset asserted mid-operation discards all slots on the next edge; no flush is signalled.
- Events are accepted from the cycle after allocation. DONE is registered, so `commit_valid` rises 1 cycle after the completing event.
- `commit_valid` holds until `commit_ready`. Events to a DONE slot are ignored.
- `flush_valid` is a 1-cycle pulse in the cycle after the mis-exit branch, carrying a registered `flush_mask`/`flush_addr`.
- `inflight` reflects the post-update state, 1 cycle after alloc, commit or flush.
- `revitalize` is a 1-cycle pulse in the cycle after the revitalizing commit handshake, with `revit_slot` set to the head.

## Configuration
- `TRIPS_REVITALIZE_EN` defined: S-morph revitalization is implemented as described.
- Not defined: the `alloc_iters` storage is removed, every commit frees the head, and `revitalize`/`revit_slot` are tied to 0.

## Test plan
- Alloc slot 0 with mask `32'h5`, writes=2, pred exit 1. Send LSID 0 and 2, two writes, then branch exit 1 → `commit_valid` the next cycle with commit_slot 0. After ready, `inflight`=0.
- Alloc 8 blocks → `alloc_ready`=0. Commit the head → `alloc_ready`=1. The 9th alloc gets `alloc_id` 0 (wrap).
- Alloc slots 0–3 and branch slot 1 with exit 2 (pred 0), target `32'h400` → next cycle `flush_valid`=1, `flush_mask=8'b00001100`, `flush_addr=32'h400`. The next alloc gets id 2.
- Slot 1 completes before slot 0 → no commit until slot 0 is DONE. Then commits occur in order 0, 1 on consecutive ready cycles.
- `morph_s`=1, iters=2, `TRIPS_REVITALIZE_EN` defined → two commits each pulse `revitalize` with slot 0 and re-arm it. The third commit frees the slot. Without the macro, the first commit frees it.
- Mid-run, assert `rst` for one cycle → all outputs 0 the next cycle, then `alloc_ready`=1.

Source files
------------

// File: rtl/block_tracker.sv
// block_tracker: age-ordered ring of in-flight speculative blocks with oldest-first
// commit, mis-exit flush and optional S-morph revitalization (TRIPS_REVITALIZE_EN).
module block_tracker #(
  parameter int NUM_SLOTS  = 8,
  parameter int MAX_STORES = 32,
  parameter int WR_W       = 6,
  parameter int EXIT_W     = 3,
  parameter int ADDR_W     = 32,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int LSID_W    = $clog2(MAX_STORES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  morph_s,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic [MAX_STORES-1:0] alloc_store_mask,
  input  logic [WR_W-1:0]       alloc_num_writes,
  input  logic [EXIT_W-1:0]     alloc_pred_exit,
  input  logic [7:0]            alloc_iters,
  output logic [SLOT_W-1:0]     alloc_id,
  input  logic                  st_valid,
  input  logic [SLOT_W-1:0]     st_slot,
  input  logic [LSID_W-1:0]     st_lsid,
  input  logic                  wr_valid,
  input  logic [SLOT_W-1:0]     wr_slot,
  input  logic                  br_valid,
  input  logic [SLOT_W-1:0]     br_slot,
  input  logic [EXIT_W-1:0]     br_exit,
  input  logic [ADDR_W-1:0]     br_target,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [SLOT_W-1:0]     commit_slot,
  output logic [ADDR_W-1:0]     commit_addr,
  output logic [EXIT_W-1:0]     commit_exit,
  output logic                  flush_valid,
  output logic [NUM_SLOTS-1:0]  flush_mask,
  output logic [ADDR_W-1:0]     flush_addr,
  output logic                  revitalize,
  output logic [SLOT_W-1:0]     revit_slot,
  output logic [NUM_SLOTS-1:0]  inflight
);

  typedef enum logic [1:0] {S_FREE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} slot_state_e;

  slot_state_e           state_q   [NUM_SLOTS];
  slot_state_e           state_d   [NUM_SLOTS];
  logic [ADDR_W-1:0]     addr_q    [NUM_SLOTS];
  logic [ADDR_W-1:0]     addr_d    [NUM_SLOTS];
  logic [MAX_STORES-1:0] mask_q    [NUM_SLOTS];
  logic [MAX_STORES-1:0] mask_d    [NUM_SLOTS];
  logic [MAX_STORES-1:0] rcv_q     [NUM_SLOTS];
  logic [MAX_STORES-1:0] rcv_d     [NUM_SLOTS];
  logic [WR_W-1:0]       nwr_q     [NUM_SLOTS];
  logic [WR_W-1:0]       nwr_d     [NUM_SLOTS];
  logic [WR_W-1:0]       wcnt_q    [NUM_SLOTS];
  logic [WR_W-1:0]       wcnt_d    [NUM_SLOTS];
  logic                  br_seen_q [NUM_SLOTS];
  logic                  br_seen_d [NUM_SLOTS];
  logic [EXIT_W-1:0]     pred_q    [NUM_SLOTS];
  logic [EXIT_W-1:0]     pred_d    [NUM_SLOTS];
  logic [EXIT_W-1:0]     exit_q    [NUM_SLOTS];
  logic [EXIT_W-1:0]     exit_d    [NUM_SLOTS];
`ifdef TRIPS_REVITALIZE_EN
  logic [7:0]            iters_q   [NUM_SLOTS];
  logic [7:0]            iters_d   [NUM_SLOTS];
`endif

  logic [SLOT_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [SLOT_W:0]      count_q, count_d;
  logic                 flush_valid_q, revit_q;
  logic [NUM_SLOTS-1:0] flush_mask_q, flush_vec;
  logic [ADDR_W-1:0]    flush_addr_q;
  logic [SLOT_W-1:0]    revit_slot_q;

  logic                 alloc_fire, commit_fire, revit_now, free_now, br_ok, mis;
  logic [SLOT_W-1:0]    br_off, off;
  logic [SLOT_W:0]      lim;

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
  // valid never depends on ready, and a held valid keeps its payload stable.
  assign alloc_ready  = !rst && (count_q < (SLOT_W+1)'(NUM_SLOTS));
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign alloc_id     = tail_q;
  assign commit_valid = (state_q[head_q] == S_DONE);
  assign commit_fire  = commit_valid && commit_ready;
  assign commit_slot  = commit_valid ? head_q : '0;
  assign commit_addr  = commit_valid ? addr_q[head_q] : '0;
  assign commit_exit  = commit_valid ? exit_q[head_q] : '0;
  assign br_ok        = br_valid && (state_q[br_slot] == S_EXEC) && !br_seen_q[br_slot];
  assign mis          = br_ok && (br_exit != pred_q[br_slot]);
  assign free_now     = commit_fire && !revit_now;

`ifdef TRIPS_REVITALIZE_EN
  assign revit_now = commit_fire && morph_s && (iters_q[head_q] != 8'd0);
`else
  logic unused_revit_inputs;
  assign unused_revit_inputs = ^{morph_s, alloc_iters};
  assign revit_now = 1'b0;
`endif

  assign flush_valid = flush_valid_q;
  assign flush_mask  = flush_mask_q;
  assign flush_addr  = flush_addr_q;
  assign revitalize  = revit_q;
  assign revit_slot  = revit_slot_q;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) inflight[i] = (state_q[i] != S_FREE);
  end

  // Younger-than-branch is judged by age offset from head; the slot allocated this
  // cycle sits at offset count_q, so extending the limit flushes it too.
  always_comb begin
    flush_vec = '0;
    off       = '0;
    br_off    = br_slot - head_q;
    lim       = count_q + {{SLOT_W{1'b0}}, alloc_fire};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      off = SLOT_W'(i) - head_q;
      if (mis && (off > br_off) && ({1'b0, off} < lim)) flush_vec[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    rcv_d     = rcv_q;
    nwr_d     = nwr_q;
    wcnt_d    = wcnt_q;
    br_seen_d = br_seen_q;
    pred_d    = pred_q;
    exit_d    = exit_q;
`ifdef TRIPS_REVITALIZE_EN
    iters_d   = iters_q;
`endif
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] == S_EXEC) begin
        if (st_valid && (st_slot == SLOT_W'(i)) && mask_q[i][st_lsid]) rcv_d[i][st_lsid] = 1'b1;
        if (wr_valid && (wr_slot == SLOT_W'(i)) && (wcnt_q[i] < nwr_q[i]))
          wcnt_d[i] = wcnt_q[i] + WR_W'(1);
        if (br_ok && (br_slot == SLOT_W'(i))) begin
          br_seen_d[i] = 1'b1;
          exit_d[i]    = br_exit;
        end
        if ((rcv_d[i] == mask_q[i]) && (wcnt_d[i] == nwr_q[i]) && br_seen_d[i])
          state_d[i] = S_DONE;
      end
      if (alloc_fire && (tail_q == SLOT_W'(i))) begin
        state_d[i]   = S_EXEC;
        addr_d[i]    = alloc_addr;
        mask_d[i]    = alloc_store_mask;
        nwr_d[i]     = alloc_num_writes;
        pred_d[i]    = alloc_pred_exit;
        rcv_d[i]     = '0;
        wcnt_d[i]    = '0;
        br_seen_d[i] = 1'b0;
        exit_d[i]    = '0;
`ifdef TRIPS_REVITALIZE_EN
        iters_d[i]   = alloc_iters;
`endif
      end
      if (commit_fire && (head_q == SLOT_W'(i))) begin
        if (revit_now) begin
          state_d[i]   = S_EXEC;
          rcv_d[i]     = '0;
          wcnt_d[i]    = '0;
          br_seen_d[i] = 1'b0;
`ifdef TRIPS_REVITALIZE_EN
          iters_d[i]   = iters_q[i] - 8'd1;
`endif
        end else begin
          state_d[i] = S_FREE;
        end
      end
      if (flush_vec[i]) state_d[i] = S_FREE;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{SLOT_W{1'b0}}, alloc_fire} - {{SLOT_W{1'b0}}, free_now};
    if (free_now)   head_d = head_q + SLOT_W'(1);
    if (alloc_fire) tail_d = tail_q + SLOT_W'(1);
    // A mis-exit truncates the ring right after the branching block.
    if (mis) begin
      tail_d  = br_slot + SLOT_W'(1);
      count_d = {1'b0, br_off} + (SLOT_W+1)'(1) - {{SLOT_W{1'b0}}, free_now};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]   <= S_FREE;
        addr_q[i]    <= '0;
        mask_q[i]    <= '0;
        rcv_q[i]     <= '0;
        nwr_q[i]     <= '0;
        wcnt_q[i]    <= '0;
        br_seen_q[i] <= 1'b0;
        pred_q[i]    <= '0;
        exit_q[i]    <= '0;
`ifdef TRIPS_REVITALIZE_EN
        iters_q[i]   <= '0;
`endif
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      flush_valid_q <= 1'b0;
      flush_mask_q  <= '0;
      flush_addr_q  <= '0;
      revit_q       <= 1'b0;
      revit_slot_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      mask_q        <= mask_d;
      rcv_q         <= rcv_d;
      nwr_q         <= nwr_d;
      wcnt_q        <= wcnt_d;
      br_seen_q     <= br_seen_d;
      pred_q        <= pred_d;
      exit_q        <= exit_d;
`ifdef TRIPS_REVITALIZE_EN
      iters_q       <= iters_d;
`endif
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_valid_q <= mis;
      flush_mask_q  <= flush_vec;
      flush_addr_q  <= mis ? br_target : '0;
      revit_q       <= revit_now;
      revit_slot_q  <= revit_now ? head_q : '0;
    end
  end

endmodule

// File: tb/tb_block_tracker.sv
// Directed plus randomized bench for block_tracker against a queue-based age-ring model.
module tb_block_tracker;
  localparam int N = 8;
`ifdef TRIPS_REVITALIZE_EN
  localparam bit REVIT_EN = 1'b1;
`else
  localparam bit REVIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        morph_s = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [31:0] alloc_addr = '0;
  logic [31:0] alloc_store_mask = '0;
  logic [5:0]  alloc_num_writes = '0;
  logic [2:0]  alloc_pred_exit = '0;
  logic [7:0]  alloc_iters = '0;
  logic [2:0]  alloc_id;
  logic        st_valid = 1'b0;
  logic [2:0]  st_slot = '0;
  logic [4:0]  st_lsid = '0;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_slot = '0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_slot = '0;
  logic [2:0]  br_exit = '0;
  logic [31:0] br_target = '0;
  logic        commit_valid;
  logic        commit_ready = 1'b0;
  logic [2:0]  commit_slot;
  logic [31:0] commit_addr;
  logic [2:0]  commit_exit;
  logic        flush_valid;
  logic [7:0]  flush_mask;
  logic [31:0] flush_addr;
  logic        revitalize;
  logic [2:0]  revit_slot;
  logic [7:0]  inflight;

  block_tracker dut (
    .clk(clk), .rst(rst), .morph_s(morph_s),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .alloc_store_mask(alloc_store_mask), .alloc_num_writes(alloc_num_writes),
    .alloc_pred_exit(alloc_pred_exit), .alloc_iters(alloc_iters), .alloc_id(alloc_id),
    .st_valid(st_valid), .st_slot(st_slot), .st_lsid(st_lsid),
    .wr_valid(wr_valid), .wr_slot(wr_slot),
    .br_valid(br_valid), .br_slot(br_slot), .br_exit(br_exit), .br_target(br_target),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_slot(commit_slot),
    .commit_addr(commit_addr), .commit_exit(commit_exit),
    .flush_valid(flush_valid), .flush_mask(flush_mask), .flush_addr(flush_addr),
    .revitalize(revitalize), .revit_slot(revit_slot), .inflight(inflight)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: slots plus an age-ordered queue of occupied slot ids
  int          m_state [N];  // 0 free, 1 executing, 2 done
  logic [31:0] m_mask [N], m_rcv [N], m_addr [N];
  int          m_nw [N], m_wc [N], m_pred [N], m_exit [N], m_iters [N];
  bit          m_br [N];
  int          ring [$];
  int          m_head;
  bit          e_fv, e_rv;
  logic [7:0]  e_fm;
  logic [31:0] e_fa;
  int          e_rs;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int n, aslot, h, p;
    bit afire, cfire, brok, mis, revit;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_state[i] = 0; m_mask[i] = 0; m_rcv[i] = 0; m_addr[i] = 0; m_nw[i] = 0;
        m_wc[i] = 0; m_pred[i] = 0; m_exit[i] = 0; m_iters[i] = 0; m_br[i] = 0;
      end
      ring.delete();
      m_head = 0; e_fv = 0; e_fm = 0; e_fa = 0; e_rv = 0; e_rs = 0;
      return;
    end
    n = ring.size();
    afire = alloc_valid && (n < N);
    aslot = (m_head + n) % N;
    cfire = (n > 0) && (m_state[ring[0]] == 2) && commit_ready;
    if (st_valid && m_state[st_slot] == 1 && m_mask[st_slot][st_lsid]) m_rcv[st_slot][st_lsid] = 1'b1;
    if (wr_valid && m_state[wr_slot] == 1 && m_wc[wr_slot] < m_nw[wr_slot]) m_wc[wr_slot]++;
    brok = br_valid && m_state[br_slot] == 1 && !m_br[br_slot];
    mis = brok && (int'(br_exit) != m_pred[br_slot]);
    if (brok) begin
      m_br[br_slot] = 1;
      m_exit[br_slot] = br_exit;
    end
    for (int i = 0; i < N; i++)
      if (m_state[i] == 1 && m_rcv[i] == m_mask[i] && m_wc[i] == m_nw[i] && m_br[i]) m_state[i] = 2;
    revit = 0;
    h = m_head;
    if (cfire) begin
      revit = REVIT_EN && morph_s && m_iters[h] > 0;
      if (revit) begin
        m_iters[h]--; m_rcv[h] = 0; m_wc[h] = 0; m_br[h] = 0; m_state[h] = 1;
      end else begin
        m_state[h] = 0;
        void'(ring.pop_front());
        m_head = (m_head + 1) % N;
      end
    end
    if (afire) begin
      m_state[aslot] = 1; m_addr[aslot] = alloc_addr; m_mask[aslot] = alloc_store_mask;
      m_nw[aslot] = alloc_num_writes; m_pred[aslot] = alloc_pred_exit;
      m_iters[aslot] = alloc_iters; m_rcv[aslot] = 0; m_wc[aslot] = 0; m_br[aslot] = 0;
      m_exit[aslot] = 0;
      ring.push_back(aslot);
    end
    e_fm = '0;
    if (mis) begin
      p = 0;
      for (int k = 0; k < ring.size(); k++) if (ring[k] == int'(br_slot)) p = k;
      while (ring.size() > p + 1) begin
        int s;
        s = ring.pop_back();
        m_state[s] = 0;
        e_fm[s] = 1'b1;
      end
    end
    e_fv = mis;
    e_fa = mis ? br_target : 32'h0;
    e_rv = revit;
    e_rs = revit ? h : 0;
  endtask

  task automatic check_outputs();
    bit cv;
    logic [7:0] inf;
    cv = ring.size() > 0 && m_state[ring[0]] == 2;
    inf = '0;
    for (int i = 0; i < N; i++) inf[i] = (m_state[i] != 0);
    chk("alloc_ready", alloc_ready, !rst && ring.size() < N);
    chk("alloc_id", alloc_id, (m_head + ring.size()) % N);
    chk("commit_valid", commit_valid, cv);
    chk("commit_slot", commit_slot, cv ? m_head : 0);
    chk("commit_addr", commit_addr, cv ? m_addr[m_head] : 0);
    chk("commit_exit", commit_exit, cv ? m_exit[m_head] : 0);
    chk("flush_valid", flush_valid, e_fv);
    chk("flush_mask", flush_mask, e_fm);
    chk("flush_addr", flush_addr, e_fa);
    chk("revitalize", revitalize, e_rv);
    chk("revit_slot", revit_slot, e_rs);
    chk("inflight", inflight, inf);
  endtask

  // driver tasks
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; st_valid = 0; wr_valid = 0; br_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    commit_ready = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] m, input int nw, input int pe, input int it);
    alloc_valid = 1; alloc_addr = a; alloc_store_mask = m;
    alloc_num_writes = 6'(nw); alloc_pred_exit = 3'(pe); alloc_iters = 8'(it);
    step();
    alloc_valid = 0;
  endtask

  task automatic branch(input int s, input int e, input logic [31:0] t);
    br_valid = 1; br_slot = 3'(s); br_exit = 3'(e); br_target = t;
    step();
    br_valid = 0;
  endtask

  initial begin
    // reset state
    rst = 1;
    step();
    step();
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_inflight", inflight, 0);
    rst = 0;

    // basic completion and commit of slot 0
    alloc(32'h1000, 32'h5, 2, 1, 0);
    st_valid = 1; st_slot = 0; st_lsid = 0; step();
    st_lsid = 2; step();
    st_valid = 0;
    wr_valid = 1; wr_slot = 0; step(); step();
    wr_valid = 0;
    chk("t1_not_done", commit_valid, 0);
    branch(0, 1, 32'h2000);
    chk("t1_cv", commit_valid, 1);
    chk("t1_cs", commit_slot, 0);
    chk("t1_caddr", commit_addr, 32'h1000);
    commit_ready = 1; step(); commit_ready = 0;
    chk("t1_inflight", inflight, 0);

    // fill to capacity, commit head, wrap
    do_reset();
    for (int k = 0; k < N; k++) alloc(32'h100 * k, 0, 0, 0, 0);
    chk("t2_full", alloc_ready, 0);
    branch(0, 0, 32'h0);
    commit_ready = 1; step(); commit_ready = 0;
    chk("t2_ready", alloc_ready, 1);
    chk("t2_wrap_id", alloc_id, 0);
    alloc(32'h9000, 0, 0, 0, 0);

    // mis-exit flush
    do_reset();
    for (int k = 0; k < 4; k++) alloc(32'h10 * k, 0, 0, 0, 0);
    branch(1, 2, 32'h400);
    chk("t3_fv", flush_valid, 1);
    chk("t3_fm", flush_mask, 8'b00001100);
    chk("t3_fa", flush_addr, 32'h400);
    chk("t3_next_id", alloc_id, 2);
    step();
    chk("t3_pulse_end", flush_valid, 0);

    // in-order commit
    do_reset();
    alloc(32'hA0, 0, 0, 0, 0);
    alloc(32'hA1, 0, 0, 0, 0);
    commit_ready = 1;
    branch(1, 0, 32'h0);
    step();
    chk("t4_wait_old", commit_valid, 0);
    branch(0, 0, 32'h0);
    chk("t4_c0", commit_slot, 0);
    step();
    chk("t4_c1_valid", commit_valid, 1);
    chk("t4_c1", commit_slot, 1);
    step();
    chk("t4_empty", inflight, 0);
    commit_ready = 0;

    // revitalization
    do_reset();
    morph_s = 1;
    alloc(32'hB0, 0, 0, 0, 2);
    commit_ready = 1;
    for (int k = 0; k < 3; k++) begin
      branch(0, 0, 32'h0);
      step();
      chk("t5_revit", revitalize, REVIT_EN && k < 2);
      chk("t5_inflight", inflight, (REVIT_EN && k < 2) ? 8'h01 : 8'h00);
    end
    commit_ready = 0;
    morph_s = 0;

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int n;
      n = ring.size();
      morph_s = (c >= 1500);
      alloc_valid = ($urandom_range(0, 99) < 40);
      alloc_addr = $urandom();
      alloc_store_mask = 32'($urandom_range(0, 15));
      alloc_num_writes = 6'($urandom_range(0, 2));
      alloc_pred_exit = 3'($urandom_range(0, 3));
      alloc_iters = 8'($urandom_range(0, 2));
      st_valid = ($urandom_range(0, 99) < 60);
      st_slot = (n > 0) ? 3'(ring[$urandom_range(0, n - 1)]) : 3'($urandom_range(0, 7));
      st_lsid = 5'($urandom_range(0, 3));
      wr_valid = ($urandom_range(0, 99) < 50);
      wr_slot = (n > 0) ? 3'(ring[$urandom_range(0, n - 1)]) : 3'($urandom_range(0, 7));
      br_valid = ($urandom_range(0, 99) < 30);
      br_slot = (n > 0) ? 3'(ring[$urandom_range(0, n - 1)]) : 3'($urandom_range(0, 7));
      br_exit = ($urandom_range(0, 99) < 85) ? 3'(m_pred[br_slot]) : 3'($urandom_range(0, 7));
      br_target = $urandom();
      commit_ready = ($urandom_range(0, 99) < 60);
      step();
    end

    // mid-run reset
    for (int k = 0; k < 3; k++) alloc(32'hC0 + k, 0, 0, 0, 0);
    idle_inputs();
    commit_ready = 0;
    rst = 1;
    step();
    chk("t6_inflight", inflight, 0);
    chk("t6_ready_in_rst", alloc_ready, 0);
    chk("t6_no_flush", flush_valid, 0);
    rst = 0;
    #1;
    chk("t6_ready_after", alloc_ready, 1);
    step();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
